// File: rtl/parafuzz_pkg.sv
// parafuzz_pkg: shared types and default secret window for the taint sink monitor.
package parafuzz_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, WAIT_AW = 2'd2} state_t;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_entry_t;
    localparam logic [31:0] DEFAULT_SECRET_BASE  = 32'h80004000;
    localparam logic [31:0] DEFAULT_SECRET_LIMIT = 32'h80005000;
    localparam int AW_ENTRY_W = $bits(aw_entry_t);
endpackage

// File: rtl/taint_sink_aw_fifo.sv
// taint_sink_aw_fifo: power-of-two FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module taint_sink_aw_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 44
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (PW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/taint_sink.sv
// taint_sink: passive AXI4 write monitor flagging tainted bursts written outside the secret window.
module taint_sink
    import parafuzz_pkg::*;
#(
    parameter int          AW_DEPTH     = 4,
    parameter logic [31:0] SECRET_BASE  = DEFAULT_SECRET_BASE,
    parameter logic [31:0] SECRET_LIMIT = DEFAULT_SECRET_LIMIT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_axi4_0_aw_ready,
    input  logic        mem_axi4_0_aw_valid,
    input  logic [3:0]  mem_axi4_0_aw_bits_id,
    input  logic [31:0] mem_axi4_0_aw_bits_addr,
    input  logic [7:0]  mem_axi4_0_aw_bits_len,
    input  logic        mem_axi4_0_w_ready,
    input  logic        mem_axi4_0_w_valid,
    input  logic        mem_axi4_0_w_bits_last,
    input  logic [63:0] mem_axi4_0_w_bits_data_taint_0,
    output logic        leak_valid,
    output logic [31:0] leak_addr,
    output logic [3:0]  leak_id,
    output logic [31:0] leak_count,
    output logic        proto_err
);
    state_t state, state_nxt;
    aw_entry_t aw_in, head, res_entry;
    logic aw_fire, w_fire, w_last_fire, w_taint;
    logic push, pop, full, empty, resolve, hold, drop_last, overflow, leak_now, len_err;
    logic [8:0] beat_cnt, wait_cnt, done_cnt, res_cnt;
    logic taint_or, wait_taint, done_taint, res_taint;
    assign aw_fire     = mem_axi4_0_aw_valid && mem_axi4_0_aw_ready;
    assign w_fire      = mem_axi4_0_w_valid && mem_axi4_0_w_ready;
    assign w_last_fire = w_fire && mem_axi4_0_w_bits_last;
    assign w_taint     = |mem_axi4_0_w_bits_data_taint_0;
    assign aw_in       = '{id: mem_axi4_0_aw_bits_id, addr: mem_axi4_0_aw_bits_addr, len: mem_axi4_0_aw_bits_len};
    assign done_cnt    = beat_cnt + 9'd1;
    assign done_taint  = taint_or | w_taint;
    taint_sink_aw_fifo #(.DEPTH(AW_DEPTH), .WIDTH(AW_ENTRY_W)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (aw_in),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );
    always_comb begin
        state_nxt = state;
        resolve   = 1'b0;
        hold      = 1'b0;
        drop_last = 1'b0;
        pop       = 1'b0;
        push      = aw_fire;
        res_cnt   = done_cnt;
        res_taint = done_taint;
        res_entry = head;
        if (state == WAIT_AW) begin
            drop_last = w_last_fire;
            // An AW arriving with the FIFO empty pairs with the held burst directly.
            if (!empty || aw_fire) begin
                resolve   = 1'b1;
                res_cnt   = wait_cnt;
                res_taint = wait_taint;
                res_entry = empty ? aw_in : head;
                pop       = !empty;
                push      = aw_fire && !empty;
                state_nxt = ((w_fire && !mem_axi4_0_w_bits_last) || (beat_cnt != '0 && !w_last_fire)) ? BURST : IDLE;
            end
        end else if (w_last_fire) begin
            resolve   = !empty;
            pop       = !empty;
            hold      = empty;
            state_nxt = empty ? WAIT_AW : IDLE;
        end else if (w_fire) begin
            state_nxt = BURST;
        end
    end
    assign overflow = push && full && !pop;
    assign len_err  = resolve && (res_cnt != ({1'b0, res_entry.len} + 9'd1));
    assign leak_now = resolve && res_taint && (res_entry.addr < SECRET_BASE || res_entry.addr >= SECRET_LIMIT);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            taint_or   <= 1'b0;
            wait_cnt   <= '0;
            wait_taint <= 1'b0;
            leak_valid <= 1'b0;
            leak_addr  <= '0;
            leak_id    <= '0;
            leak_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (w_last_fire) begin
                beat_cnt <= '0;
                taint_or <= 1'b0;
            end else if (w_fire) begin
                beat_cnt <= beat_cnt + 9'd1;
                taint_or <= taint_or | w_taint;
            end
            if (hold) begin
                wait_cnt   <= done_cnt;
                wait_taint <= done_taint;
            end
            leak_valid <= leak_now;
            if (leak_now) begin
                leak_addr <= res_entry.addr;
                leak_id   <= res_entry.id;
                if (leak_count != '1) leak_count <= leak_count + 32'd1;
            end
            if (overflow || drop_last || len_err) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_taint_sink.sv
// tb_taint_sink: table-driven directed checks of the taint sink plus a full-FIFO push/pop sequence.
module tb_taint_sink;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic aw_ready = 1'b0, aw_valid = 1'b0, w_ready = 1'b0, w_valid = 1'b0, w_last = 1'b0;
    logic [3:0] aw_id = '0;
    logic [31:0] aw_addr = '0;
    logic [7:0] aw_len = '0;
    logic [63:0] w_taint = '0;
    logic leak_valid, proto_err;
    logic [31:0] leak_addr, leak_count;
    logic [3:0] leak_id;
    int checks = 0;
    int errors = 0;
    int row = 0;

    typedef struct packed {
        logic        rst;
        logic        awv;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        wv;
        logic        wl;
        logic [63:0] t;
        logic        ev;
        logic [31:0] ea;
        logic [3:0]  ei;
        logic [31:0] ec;
        logic        ep;
    } vec_t;
    vec_t tbl[$];

    always #5 clock = ~clock;

    taint_sink dut (
        .clock                          (clock),
        .reset                          (reset),
        .mem_axi4_0_aw_ready            (aw_ready),
        .mem_axi4_0_aw_valid            (aw_valid),
        .mem_axi4_0_aw_bits_id          (aw_id),
        .mem_axi4_0_aw_bits_addr        (aw_addr),
        .mem_axi4_0_aw_bits_len         (aw_len),
        .mem_axi4_0_w_ready             (w_ready),
        .mem_axi4_0_w_valid             (w_valid),
        .mem_axi4_0_w_bits_last         (w_last),
        .mem_axi4_0_w_bits_data_taint_0 (w_taint),
        .leak_valid                     (leak_valid),
        .leak_addr                      (leak_addr),
        .leak_id                        (leak_id),
        .leak_count                     (leak_count),
        .proto_err                      (proto_err)
    );

    function automatic vec_t v(logic rst, logic awv, logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                               logic wv, logic wl, logic [63:0] t,
                               logic ev, logic [31:0] ea, logic [3:0] ei, logic [31:0] ec, logic ep);
        return '{rst: rst, awv: awv, id: id, addr: addr, len: len, wv: wv, wl: wl, t: t,
                 ev: ev, ea: ea, ei: ei, ec: ec, ep: ep};
    endfunction

    task automatic step(input logic rs, input logic awv, input logic awr, input logic [3:0] id,
                        input logic [31:0] addr, input logic [7:0] len,
                        input logic wv, input logic wr, input logic wl, input logic [63:0] t);
        reset = rs;
        aw_valid = awv; aw_ready = awr; aw_id = id; aw_addr = addr; aw_len = len;
        w_valid = wv; w_ready = wr; w_last = wl; w_taint = t;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input logic ev, input logic [31:0] ea, input logic [3:0] ei,
                           input logic [31:0] ec, input logic ep);
        chk("leak_valid", 32'(leak_valid), 32'(ev));
        chk("leak_addr", leak_addr, ea);
        chk("leak_id", 32'(leak_id), 32'(ei));
        chk("leak_count", leak_count, ec);
        chk("proto_err", 32'(proto_err), 32'(ep));
    endtask

    localparam logic [63:0] T1 = 64'h1;
    localparam logic [63:0] TA = '1;

    initial begin
        // reset state
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // AW inside window, one all-ones tainted beat: no leak
        tbl.push_back(v(0, 1, 2, 32'h80004800, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, TA, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // AW outside window len 3, taint on second beat
        tbl.push_back(v(0, 1, 1, 32'h80008000, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, T1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h80008000, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80008000, 1, 1, 0));
        // W burst before its AW: wait, then leak one cycle after the AW
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, 64'hFF, 0, 32'h80008000, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h80008000, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80008000, 1, 1, 0));
        tbl.push_back(v(0, 1, 3, 32'h80000000, 1, 0, 0, 0, 1, 32'h80000000, 3, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80000000, 3, 2, 0));
        // short burst: length error but taint still evaluated
        tbl.push_back(v(0, 1, 4, 32'h90000000, 3, 0, 0, 0, 0, 32'h80000000, 3, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, T1, 0, 32'h80000000, 3, 2, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 1, 32'h90000000, 4, 3, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h90000000, 4, 3, 1));
        // overflow: 5 AWs into a depth-4 FIFO, 4 retained
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 5, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 6, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 8, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 9, 32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, T1, 1, 32'h100, 5, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, T1, 1, 32'h200, 6, 2, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, T1, 1, 32'h300, 7, 3, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, T1, 1, 32'h400, 8, 4, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, T1, 0, 32'h400, 8, 4, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 8, 4, 1));
        // reset mid-burst discards the tainted partial burst
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 0, TA, 0, 32'h400, 8, 4, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 2, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clock);
        #1;
        foreach (tbl[i]) begin
            row = i;
            step(tbl[i].rst, tbl[i].awv, 1'b1, tbl[i].id, tbl[i].addr, tbl[i].len,
                 tbl[i].wv, 1'b1, tbl[i].wl, tbl[i].t);
            chk_all(tbl[i].ev, tbl[i].ea, tbl[i].ei, tbl[i].ec, tbl[i].ep);
        end

        // full FIFO: simultaneous push and pop both take effect
        row = 100;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 1, 4'(k), 32'hA00 + 32'(k) * 32'h10, 0, 0, 1, 0, 0);
            chk_all(0, 0, 0, 0, 0);
        end
        row = 104;
        step(0, 1, 1, 4'd4, 32'hA40, 0, 1, 1, 1, T1);
        chk_all(1, 32'hA00, 0, 1, 0);
        // AW valid without ready and W valid without ready are not beats
        row = 105;
        step(0, 1, 0, 4'd9, 32'hBEEF, 0, 1, 0, 1, T1);
        chk_all(0, 32'hA00, 0, 1, 0);
        for (int k = 1; k < 5; k++) begin
            row = 105 + k;
            step(0, 0, 1, 0, 0, 0, 1, 1, 1, T1);
            chk_all(1, 32'hA00 + 32'(k) * 32'h10, 4'(k), 32'(k + 1), 0);
        end
        row = 110;
        step(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        chk_all(0, 32'hA40, 4, 5, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
